// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, ALU opcodes, forward selects
// and the ID/EX latch payload.
package cpu_types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } aluop_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic     valid;
        word_t    rdat1;
        word_t    rdat2;
        word_t    imm;
        logic     alusrc;
        aluop_t   aluop;
        regbits_t rs;
        regbits_t rt;
        regbits_t wsel;
        logic     regwen;
    } id_ex_t;

    // All-zero bubble; aluop lands on encoding 4'b0000.
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/ex_operand_latch_fwd_unit.sv
// Per-operand RAW forwarding mux: EX/MEM beats MEM/WB, register 0 never forwards.
module fwd_unit
    import cpu_types_pkg::*;
(
    input  regbits_t rsel,
    input  word_t    rdat,
    input  logic     exmem_regwen,
    input  regbits_t exmem_wsel,
    input  word_t    exmem_result,
    input  logic     memwb_regwen,
    input  regbits_t memwb_wsel,
    input  word_t    memwb_wdat,
    output word_t    fwd_dat_c,
    output fwd_sel_t fwd_sel_c
);

    always_comb begin
        fwd_dat_c = rdat;
        fwd_sel_c = FWD_NONE;
        if (rsel != '0) begin
            if (exmem_regwen && (exmem_wsel == rsel)) begin
                fwd_dat_c = exmem_result;
                fwd_sel_c = FWD_EXMEM;
            end else if (memwb_regwen && (memwb_wsel == rsel)) begin
                fwd_dat_c = memwb_wdat;
                fwd_sel_c = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/ex_operand_latch.sv
// ID/EX pipeline latch with operand forwarding feeding the ALU; stalls refresh
// the latched register data with its forwarded value.
module ex_operand_latch
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    input  logic     stall,
    input  logic     flush,
    input  logic     id_valid,
    input  word_t    id_rdat1,
    input  word_t    id_rdat2,
    input  word_t    id_imm,
    input  logic     id_alusrc,
    input  aluop_t   id_aluop,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  regbits_t id_wsel,
    input  logic     id_regwen,
    input  logic     exmem_regwen,
    input  regbits_t exmem_wsel,
    input  word_t    exmem_result,
    input  logic     memwb_regwen,
    input  regbits_t memwb_wsel,
    input  word_t    memwb_wdat,
    output word_t    port_a,
    output word_t    port_b,
    output aluop_t   alu_op,
    output logic     ex_valid,
    output logic     ex_regwen,
    output regbits_t ex_wsel,
    output word_t    ex_store_dat
);

    id_ex_t   lat;
    id_ex_t   id_load;
    word_t    fwd_a;
    word_t    fwd_b;
    fwd_sel_t unused_sel_a;
    fwd_sel_t unused_sel_b;

    always_comb begin
        id_load        = ID_EX_BUBBLE;
        id_load.valid  = id_valid;
        id_load.rdat1  = id_rdat1;
        id_load.rdat2  = id_rdat2;
        id_load.imm    = id_imm;
        id_load.alusrc = id_alusrc;
        id_load.aluop  = id_aluop;
        id_load.rs     = id_rs;
        id_load.rt     = id_rt;
        id_load.wsel   = id_wsel;
        id_load.regwen = id_regwen;
    end

    // Reset beats flush beats stall; a stall re-captures forwarded operands.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            lat <= ID_EX_BUBBLE;
        end else if (flush) begin
            lat <= ID_EX_BUBBLE;
        end else if (stall) begin
            lat.rdat1 <= fwd_a;
            lat.rdat2 <= fwd_b;
        end else begin
            lat <= id_load;
        end
    end

    fwd_unit u_fwd_a (
        .rsel         (lat.rs),
        .rdat         (lat.rdat1),
        .exmem_regwen (exmem_regwen),
        .exmem_wsel   (exmem_wsel),
        .exmem_result (exmem_result),
        .memwb_regwen (memwb_regwen),
        .memwb_wsel   (memwb_wsel),
        .memwb_wdat   (memwb_wdat),
        .fwd_dat_c    (fwd_a),
        .fwd_sel_c    (unused_sel_a)
    );

    fwd_unit u_fwd_b (
        .rsel         (lat.rt),
        .rdat         (lat.rdat2),
        .exmem_regwen (exmem_regwen),
        .exmem_wsel   (exmem_wsel),
        .exmem_result (exmem_result),
        .memwb_regwen (memwb_regwen),
        .memwb_wsel   (memwb_wsel),
        .memwb_wdat   (memwb_wdat),
        .fwd_dat_c    (fwd_b),
        .fwd_sel_c    (unused_sel_b)
    );

    assign port_a       = fwd_a;
    assign port_b       = lat.alusrc ? lat.imm : fwd_b;
    assign ex_store_dat = fwd_b;
    assign alu_op       = lat.aluop;
    assign ex_valid     = lat.valid;
    assign ex_regwen    = lat.regwen;
    assign ex_wsel      = lat.wsel;

endmodule

// File: tb/tb_ex_operand_latch.sv
// Directed and randomized bench for ex_operand_latch against a behavioural model.
module tb_ex_operand_latch;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     nRST;
    logic     stall, flush;
    logic     id_valid;
    word_t    id_rdat1, id_rdat2, id_imm;
    logic     id_alusrc;
    aluop_t   id_aluop;
    regbits_t id_rs, id_rt, id_wsel;
    logic     id_regwen;
    logic     exmem_regwen;
    regbits_t exmem_wsel;
    word_t    exmem_result;
    logic     memwb_regwen;
    regbits_t memwb_wsel;
    word_t    memwb_wdat;
    word_t    port_a, port_b, ex_store_dat;
    aluop_t   alu_op;
    logic     ex_valid, ex_regwen;
    regbits_t ex_wsel;

    int checks = 0;
    int errors = 0;

    // Reference pipeline slot: what the ID/EX register should hold right now.
    logic        m_valid, m_alusrc, m_regwen;
    logic [31:0] m_rdat1, m_rdat2, m_imm;
    logic [3:0]  m_aluop;
    logic [4:0]  m_rs, m_rt, m_wsel;

    ex_operand_latch dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .stall        (stall),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rdat1     (id_rdat1),
        .id_rdat2     (id_rdat2),
        .id_imm       (id_imm),
        .id_alusrc    (id_alusrc),
        .id_aluop     (id_aluop),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_wsel      (id_wsel),
        .id_regwen    (id_regwen),
        .exmem_regwen (exmem_regwen),
        .exmem_wsel   (exmem_wsel),
        .exmem_result (exmem_result),
        .memwb_regwen (memwb_regwen),
        .memwb_wsel   (memwb_wsel),
        .memwb_wdat   (memwb_wdat),
        .port_a       (port_a),
        .port_b       (port_b),
        .alu_op       (alu_op),
        .ex_valid     (ex_valid),
        .ex_regwen    (ex_regwen),
        .ex_wsel      (ex_wsel),
        .ex_store_dat (ex_store_dat)
    );

    always #5 CLK = ~CLK;

    // Value an ALU reading register r would see given the pipeline contents.
    function automatic logic [31:0] ref_read(input logic [4:0] r, input logic [31:0] latched);
        if (r == 5'd0) return latched;
        if (exmem_regwen && exmem_wsel == r) return exmem_result;
        if (memwb_regwen && memwb_wsel == r) return memwb_wdat;
        return latched;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] b_val;
        b_val = ref_read(m_rt, m_rdat2);
        chk({tag, ".port_a"},    port_a,                ref_read(m_rs, m_rdat1));
        chk({tag, ".port_b"},    port_b,                m_alusrc ? m_imm : b_val);
        chk({tag, ".store"},     ex_store_dat,          b_val);
        chk({tag, ".alu_op"},    32'(alu_op),           32'(m_aluop));
        chk({tag, ".ex_valid"},  32'(ex_valid),         32'(m_valid));
        chk({tag, ".ex_regwen"}, 32'(ex_regwen),        32'(m_regwen));
        chk({tag, ".ex_wsel"},   32'(ex_wsel),          32'(m_wsel));
    endtask

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        logic        bubble, hold;
        logic [31:0] r1, r2;
        bubble = !nRST || flush;
        hold   = stall && !bubble;
        r1 = ref_read(m_rs, m_rdat1);
        r2 = ref_read(m_rt, m_rdat2);
        @(posedge CLK);
        if (bubble) begin
            {m_valid, m_alusrc, m_regwen} = 3'b000;
            {m_rdat1, m_rdat2, m_imm} = '0;
            m_aluop = 4'd0;
            {m_rs, m_rt, m_wsel} = '0;
        end else if (hold) begin
            m_rdat1 = r1;
            m_rdat2 = r2;
        end else begin
            m_valid  = id_valid;   m_alusrc = id_alusrc; m_regwen = id_regwen;
            m_rdat1  = id_rdat1;   m_rdat2  = id_rdat2;  m_imm    = id_imm;
            m_aluop  = 4'(id_aluop);
            m_rs     = id_rs;      m_rt     = id_rt;     m_wsel   = id_wsel;
        end
        #1;
    endtask

    task automatic rand_id();
        id_valid  = 1'($urandom);
        id_rdat1  = $urandom;
        id_rdat2  = $urandom;
        id_imm    = $urandom;
        id_alusrc = 1'($urandom);
        id_aluop  = aluop_t'(4'($urandom_range(0, 9)));
        id_rs     = 5'($urandom_range(0, 7));
        id_rt     = 5'($urandom_range(0, 7));
        id_wsel   = 5'($urandom);
        id_regwen = 1'($urandom);
    endtask

    task automatic rand_fwd();
        exmem_regwen = 1'($urandom);
        exmem_wsel   = 5'($urandom_range(0, 7));
        exmem_result = $urandom;
        memwb_regwen = 1'($urandom);
        memwb_wsel   = 5'($urandom_range(0, 7));
        memwb_wdat   = $urandom;
    endtask

    task automatic load_one(input logic [4:0] rs, input logic [31:0] r1,
                            input logic [4:0] rt, input logic [31:0] r2,
                            input logic [31:0] imm, input logic src);
        stall = 0; flush = 0; nRST = 1;
        id_valid = 1; id_regwen = 1; id_wsel = 5'd9; id_aluop = ALU_ADD;
        id_rs = rs; id_rdat1 = r1; id_rt = rt; id_rdat2 = r2;
        id_imm = imm; id_alusrc = src;
        exmem_regwen = 0; memwb_regwen = 0;
        tick();
    endtask

    initial begin
        // Reset with garbage on every input
        nRST = 0; stall = 1'($urandom); flush = 0;
        rand_id(); rand_fwd();
        tick(); tick();
        exmem_regwen = 0; memwb_regwen = 0; #1;
        chk("reset.ex_valid", 32'(ex_valid), 32'd0);
        chk("reset.alu_op",   32'(alu_op),   32'd0);
        chk("reset.port_a",   port_a,        32'd0);
        chk("reset.port_b",   port_b,        32'd0);
        rand_fwd(); #1;
        chk("reset.port_a_fwd", port_a, 32'd0);
        chk_model("reset");

        // Plain load through the immediate path
        load_one(5'd1, 32'h5, 5'd2, 32'h3, 32'h10, 1'b1);
        chk("load.port_a",   port_a,          32'h5);
        chk("load.port_b",   port_b,          32'h10);
        chk("load.ex_valid", 32'(ex_valid),   32'd1);
        chk("load.alu_op",   32'(alu_op),     32'(ALU_ADD));
        chk_model("load");

        // EX/MEM wins over MEM/WB on the same register
        load_one(5'd8, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0);
        exmem_regwen = 1; exmem_wsel = 5'd8; exmem_result = 32'hAA;
        memwb_regwen = 1; memwb_wsel = 5'd8; memwb_wdat   = 32'hBB; #1;
        chk("prio.exmem", port_a, 32'hAA);
        exmem_regwen = 0; #1;
        chk("prio.memwb", port_a, 32'hBB);
        chk_model("prio");

        // Register 0 never forwards
        load_one(5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
        exmem_regwen = 1; exmem_wsel = 5'd0; exmem_result = 32'hFF; #1;
        chk("zero.port_a", port_a, 32'h0);
        chk("zero.port_b", port_b, 32'h0);

        // Stall captures a value retiring from MEM/WB
        load_one(5'd4, 32'h4, 5'd3, 32'h1, 32'h0, 1'b0);
        chk("refresh.stale", port_b, 32'h1);
        stall = 1; rand_id();
        memwb_regwen = 1; memwb_wsel = 5'd3; memwb_wdat = 32'h77; #1;
        chk("refresh.fwd", port_b, 32'h77);
        tick();
        memwb_wsel = 5'd5; memwb_wdat = 32'h99; #1;
        chk("refresh.port_b", port_b,       32'h77);
        chk("refresh.store",  ex_store_dat, 32'h77);
        chk("refresh.hold_valid", 32'(ex_valid), 32'd1);

        // Stall and flush together give a bubble
        stall = 1; flush = 1; id_valid = 1; id_regwen = 1;
        tick();
        flush = 0; stall = 0; #1;
        chk("sf.ex_valid",  32'(ex_valid),  32'd0);
        chk("sf.ex_regwen", 32'(ex_regwen), 32'd0);

        // Reset during a stall clears the latch
        load_one(5'd1, 32'h12, 5'd2, 32'h34, 32'h0, 1'b0);
        stall = 1; nRST = 0;
        tick();
        nRST = 1; stall = 0; exmem_regwen = 0; memwb_regwen = 0; #1;
        chk("rststall.ex_valid", 32'(ex_valid), 32'd0);
        chk("rststall.port_a",   port_a,        32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            nRST  = ($urandom_range(0, 99) >= 3);
            stall = ($urandom_range(0, 99) < 30);
            flush = ($urandom_range(0, 99) < 10);
            rand_id();
            rand_fwd();
            #1;
            chk_model("rand");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
